// File: rtl/pipe_control_unit.sv
// -----------------------------------------------------------------------------
// pipe_control_unit
// Main decoder plus ID/EX, EX/MEM and MEM/WB control registers for a 5-stage
// RISC-V style pipeline. It also squashes flushed instructions, freezes the
// pipeline on an external stall, and counts illegal opcodes (saturating).
//
// Optional feature: define PIPE_CTRL_HAZARD_DETECT_EN to enable load-use
// hazard detection. With the macro undefined, hazard is tied to 0 and
// id_stall simply follows stall_in.
//
// Ports
//   clk, reset           clock and synchronous active-high reset
//   in_valid, opcode     IF/ID instruction valid flag and instruction[6:0]
//   rs1, rs2, rd         register indices from IF/ID
//   stall_in             external freeze; all stage registers hold
//   flush                squash the instruction currently in ID
//   id_stall             hold PC and IF/ID this cycle
//   ex_*                 ID/EX register outputs
//   mem_*                EX/MEM register outputs
//   wb_*                 MEM/WB register outputs
//   illegal              combinational: valid instruction with unknown opcode
//   illegal_cnt          saturating count of illegal instructions reaching EX
// -----------------------------------------------------------------------------
module pipe_control_unit #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [6:0]         opcode,
    input  logic [REG_W-1:0]   rs1,
    input  logic [REG_W-1:0]   rs2,
    input  logic [REG_W-1:0]   rd,
    input  logic               stall_in,
    input  logic               flush,
    output logic               id_stall,
    output logic               ex_valid,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               ex_alusrc,
    output logic               ex_memread,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_W-1:0]   ex_rd,
    output logic               mem_valid,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_memtoreg,
    output logic               mem_regwrite,
    output logic [REG_W-1:0]   mem_rd,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_rd,
    output logic               illegal,
    output logic [7:0]         illegal_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Decoder outputs
    logic               dec_legal;
    logic               dec_branch, dec_jump, dec_memread, dec_memtoreg;
    logic               dec_memwrite, dec_alusrc, dec_regwrite;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_valid;
    logic               hazard;
    logic               load_idex;

    // ID/EX register, including the bits only needed further down
    logic               ex_valid_reg, ex_branch_reg, ex_jump_reg, ex_alusrc_reg;
    logic               ex_memread_reg, ex_memwrite_reg, ex_memtoreg_reg, ex_regwrite_reg;
    logic [ALUOP_W-1:0] ex_aluop_reg;
    logic [REG_W-1:0]   ex_rd_reg;
    logic               ex_valid_next, ex_branch_next, ex_jump_next, ex_alusrc_next;
    logic               ex_memread_next, ex_memwrite_next, ex_memtoreg_next, ex_regwrite_next;
    logic [ALUOP_W-1:0] ex_aluop_next;
    logic [REG_W-1:0]   ex_rd_next;

    // EX/MEM and MEM/WB registers
    logic               mem_valid_reg, mem_memread_reg, mem_memwrite_reg;
    logic               mem_memtoreg_reg, mem_regwrite_reg;
    logic [REG_W-1:0]   mem_rd_reg;
    logic               wb_valid_reg, wb_regwrite_reg, wb_memtoreg_reg;
    logic [REG_W-1:0]   wb_rd_reg;
    logic [7:0]         illegal_cnt_reg;

    always_comb begin
        dec_legal    = 1'b1;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_memread  = 1'b0;
        dec_memtoreg = 1'b0;
        dec_memwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_regwrite = 1'b0;
        dec_aluop    = '0;
        case (opcode)
            OP_R: begin
                dec_regwrite = 1'b1;
                dec_aluop    = ALUOP_W'(2'b10);
            end
            OP_LOAD: begin
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_IALU: begin
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = ALUOP_W'(2'b11);
            end
            OP_STORE: begin
                dec_memwrite = 1'b1;
                dec_alusrc   = 1'b1;
            end
            OP_BR: begin
                dec_branch   = 1'b1;
                dec_aluop    = ALUOP_W'(2'b01);
            end
            OP_JALR, OP_JAL: begin
                dec_jump     = 1'b1;
                dec_memtoreg = 1'b1;
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign illegal   = in_valid & ~dec_legal;
    assign dec_valid = in_valid & dec_legal;

`ifdef PIPE_CTRL_HAZARD_DETECT_EN
    logic uses_rs1, uses_rs2;
    assign uses_rs1 = dec_legal & (opcode != OP_JAL);
    assign uses_rs2 = (opcode == OP_R) | (opcode == OP_STORE) | (opcode == OP_BR);
    // A load still in EX cannot forward its data in time to the next
    // instruction, so that consumer must wait one cycle.
    assign hazard = dec_valid & ex_valid_reg & ex_memread_reg & (ex_rd_reg != '0) &
                    ((uses_rs1 & (rs1 == ex_rd_reg)) | (uses_rs2 & (rs2 == ex_rd_reg)));
`else
    assign hazard = 1'b0;
`endif

    assign id_stall  = stall_in | (hazard & ~flush);
    // Only a legal, unflushed, hazard-free instruction leaves ID; everything
    // else inserts a bubble so no control bit can fire from it.
    assign load_idex = dec_valid & ~flush & ~hazard;

    always_comb begin
        ex_valid_next    = 1'b0;
        ex_branch_next   = 1'b0;
        ex_jump_next     = 1'b0;
        ex_alusrc_next   = 1'b0;
        ex_memread_next  = 1'b0;
        ex_memwrite_next = 1'b0;
        ex_memtoreg_next = 1'b0;
        ex_regwrite_next = 1'b0;
        ex_aluop_next    = '0;
        ex_rd_next       = '0;
        if (load_idex) begin
            ex_valid_next    = 1'b1;
            ex_branch_next   = dec_branch;
            ex_jump_next     = dec_jump;
            ex_alusrc_next   = dec_alusrc;
            ex_memread_next  = dec_memread;
            ex_memwrite_next = dec_memwrite;
            ex_memtoreg_next = dec_memtoreg;
            ex_regwrite_next = dec_regwrite;
            ex_aluop_next    = dec_aluop;
            // rd is meaningless without a register write; keep it 0
            ex_rd_next       = dec_regwrite ? rd : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg     <= 1'b0;
            ex_branch_reg    <= 1'b0;
            ex_jump_reg      <= 1'b0;
            ex_alusrc_reg    <= 1'b0;
            ex_memread_reg   <= 1'b0;
            ex_memwrite_reg  <= 1'b0;
            ex_memtoreg_reg  <= 1'b0;
            ex_regwrite_reg  <= 1'b0;
            ex_aluop_reg     <= '0;
            ex_rd_reg        <= '0;
            mem_valid_reg    <= 1'b0;
            mem_memread_reg  <= 1'b0;
            mem_memwrite_reg <= 1'b0;
            mem_memtoreg_reg <= 1'b0;
            mem_regwrite_reg <= 1'b0;
            mem_rd_reg       <= '0;
            wb_valid_reg     <= 1'b0;
            wb_regwrite_reg  <= 1'b0;
            wb_memtoreg_reg  <= 1'b0;
            wb_rd_reg        <= '0;
            illegal_cnt_reg  <= 8'd0;
        end else if (!stall_in) begin
            ex_valid_reg     <= ex_valid_next;
            ex_branch_reg    <= ex_branch_next;
            ex_jump_reg      <= ex_jump_next;
            ex_alusrc_reg    <= ex_alusrc_next;
            ex_memread_reg   <= ex_memread_next;
            ex_memwrite_reg  <= ex_memwrite_next;
            ex_memtoreg_reg  <= ex_memtoreg_next;
            ex_regwrite_reg  <= ex_regwrite_next;
            ex_aluop_reg     <= ex_aluop_next;
            ex_rd_reg        <= ex_rd_next;
            // Bubbles are all-zero already, so downstream stages copy as-is.
            mem_valid_reg    <= ex_valid_reg;
            mem_memread_reg  <= ex_memread_reg;
            mem_memwrite_reg <= ex_memwrite_reg;
            mem_memtoreg_reg <= ex_memtoreg_reg;
            mem_regwrite_reg <= ex_regwrite_reg;
            mem_rd_reg       <= ex_rd_reg;
            wb_valid_reg     <= mem_valid_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            wb_memtoreg_reg  <= mem_memtoreg_reg;
            wb_rd_reg        <= mem_rd_reg;
            // hazard is never raised for an illegal opcode, so only flush
            // can keep an illegal instruction from counting
            if (illegal && !flush && illegal_cnt_reg != 8'hFF)
                illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
        end
    end

    assign ex_valid     = ex_valid_reg;
    assign ex_branch    = ex_branch_reg;
    assign ex_jump      = ex_jump_reg;
    assign ex_alusrc    = ex_alusrc_reg;
    assign ex_memread   = ex_memread_reg;
    assign ex_aluop     = ex_aluop_reg;
    assign ex_rd        = ex_rd_reg;
    assign mem_valid    = mem_valid_reg;
    assign mem_memread  = mem_memread_reg;
    assign mem_memwrite = mem_memwrite_reg;
    assign mem_memtoreg = mem_memtoreg_reg;
    assign mem_regwrite = mem_regwrite_reg;
    assign mem_rd       = mem_rd_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_regwrite  = wb_regwrite_reg;
    assign wb_memtoreg  = wb_memtoreg_reg;
    assign wb_rd        = wb_rd_reg;
    assign illegal_cnt  = illegal_cnt_reg;

endmodule

// File: tb/tb_pipe_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_control_unit
// Directed bench for pipe_control_unit. Stimulus pushes the expected write-back
// triple {regwrite, memtoreg, rd} of every instruction accepted into EX; a
// negedge monitor pops and compares whenever MEM/WB presents a new valid entry.
// Direct checks cover decode fields, id_stall, illegal and illegal_cnt.
// -----------------------------------------------------------------------------
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       reset, in_valid, stall_in, flush;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       id_stall, ex_valid, ex_branch, ex_jump, ex_alusrc, ex_memread;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic       wb_valid, wb_regwrite, wb_memtoreg, illegal;
    logic [7:0] illegal_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] wb_q[$];
    logic       adv_q = 1'b0;

    pipe_control_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .stall_in(stall_in), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
        .ex_aluop(ex_aluop), .ex_rd(ex_rd), .mem_valid(mem_valid),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_rd(wb_rd), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // MEM/WB only takes a new value on an edge without reset or stall
    always @(posedge clk) adv_q <= !reset && !stall_in;

    always @(negedge clk) begin
        if (adv_q && wb_valid) begin
            if (wb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got %0h expected none at %0t",
                         {wb_regwrite, wb_memtoreg, wb_rd}, $time);
            end else begin
                chk("wb_entry", {wb_regwrite, wb_memtoreg, wb_rd}, wb_q.pop_front());
            end
        end
        if (!wb_valid)  chk("wb_bubble", {wb_regwrite, wb_memtoreg, wb_rd}, 0);
        if (!mem_valid) chk("mem_bubble", {mem_memread, mem_memwrite, mem_memtoreg,
                                           mem_regwrite, mem_rd}, 0);
    end

    // Decode table: opcode, {branch,jump,alusrc,memread,aluop}, {regwrite,memtoreg}
    logic [6:0] t_op [7];
    logic [5:0] t_ex [7];
    logic [1:0] t_wb [7];

    initial begin
        t_op = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h67, 7'h6F};
        t_ex = '{6'b0000_10, 6'b0011_00, 6'b0010_11, 6'b0010_00,
                 6'b1000_01, 6'b0110_00, 6'b0110_00};
        t_wb = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11};

        // Reset overrides stall and flush
        reset = 1'b1; in_valid = 1'b1; opcode = 7'h33; rs1 = 0; rs2 = 0; rd = 5'd5;
        stall_in = 1'b1; flush = 1'b1;
        step(); step();
        chk("reset_valids", {ex_valid, mem_valid, wb_valid}, 0);
        chk("reset_cnt", illegal_cnt, 0);
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #1 chk("id_stall_follows_stall1", id_stall, 1);
        stall_in = 1'b0;
        #1 chk("id_stall_follows_stall0", id_stall, 0);

        // R-type rd=5 through to WB
        in_valid = 1'b1; opcode = 7'h33; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd5;
        #1 chk("r_illegal", illegal, 0);
        wb_q.push_back({1'b1, 1'b0, 5'd5});
        step();
        chk("r_ex_valid", ex_valid, 1);
        chk("r_ex_aluop", ex_aluop, 2'b10);
        chk("r_ex_rd", ex_rd, 5);
        in_valid = 1'b0;
        step(); step();
        chk("r_wb", {wb_valid, wb_regwrite, wb_rd}, {1'b1, 1'b1, 5'd5});
        step();

        // Whole decode table back to back (rs=0 so no hazard)
        rs1 = 0; rs2 = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; opcode = t_op[i]; rd = 5'(i + 1);
            wb_q.push_back({t_wb[i], t_wb[i][1] ? 5'(i + 1) : 5'd0});
            step();
            chk("tbl_ex", {ex_valid, ex_branch, ex_jump, ex_alusrc, ex_memread, ex_aluop},
                {1'b1, t_ex[i]});
            chk("tbl_ex_rd", ex_rd, t_wb[i][1] ? 5'(i + 1) : 5'd0);
            if (i > 0)
                chk("tbl_mem", {mem_valid, mem_memread, mem_memwrite},
                    {1'b1, t_op[i-1] == 7'h03, t_op[i-1] == 7'h23});
        end
        in_valid = 1'b0;
        step(); step(); step();

        // Load rd=3 followed by R reading rs2=3
        in_valid = 1'b1; opcode = 7'h03; rd = 5'd3; rs1 = 0; rs2 = 0;
        wb_q.push_back({1'b1, 1'b1, 5'd3});
        step();
        opcode = 7'h33; rs2 = 5'd3; rd = 5'd6;
        wb_q.push_back({1'b1, 1'b0, 5'd6});
`ifdef PIPE_CTRL_HAZARD_DETECT_EN
        #1 chk("hz_id_stall", id_stall, 1);
        step();
        chk("hz_bubble", {ex_valid, ex_memread, ex_rd}, 0);
        chk("hz_id_stall_clear", id_stall, 0);
        step();
        chk("hz_r_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd6});
`else
        #1 chk("nohz_id_stall", id_stall, 0);
        step();
        chk("nohz_r_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd6});
`endif
        in_valid = 1'b0;
        step(); step(); step();

        // Load rd=0 then R reading x0: never a hazard
        in_valid = 1'b1; opcode = 7'h03; rd = 5'd0; rs1 = 0; rs2 = 0;
        wb_q.push_back({1'b1, 1'b1, 5'd0});
        step();
        opcode = 7'h33; rd = 5'd7;
        #1 chk("x0_id_stall", id_stall, 0);
        wb_q.push_back({1'b1, 1'b0, 5'd7});
        step();
        chk("x0_r_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd7});
        in_valid = 1'b0;
        step(); step(); step();

        // Flush a store in ID
        in_valid = 1'b1; opcode = 7'h23; rd = 5'd9; flush = 1'b1;
        #1 chk("fl_id_stall", id_stall, 0);
        step();
        chk("fl_ex_bubble", {ex_valid, ex_branch, ex_jump, ex_alusrc, ex_memread,
                             ex_aluop, ex_rd}, 0);
        in_valid = 1'b0; flush = 1'b0;
        step();
        chk("fl_no_memwrite", {mem_valid, mem_memwrite}, 0);
        step();

        // Stall with flush held: everything freezes
        in_valid = 1'b1; opcode = 7'h33; rd = 5'd10;
        wb_q.push_back({1'b1, 1'b0, 5'd10});
        step();
        rd = 5'd11; stall_in = 1'b1; flush = 1'b1;
        #1 chk("st_id_stall", id_stall, 1);
        step(); step();
        chk("st_ex_hold", {ex_valid, ex_rd}, {1'b1, 5'd10});
        chk("st_mem_hold", mem_valid, 0);
        stall_in = 1'b0;
        #1 chk("st_release_id_stall", id_stall, 0);
        step();
        chk("st_flushed", ex_valid, 0);
        chk("st_mem_adv", {mem_valid, mem_rd}, {1'b1, 5'd10});
        in_valid = 1'b0; flush = 1'b0;
        step(); step(); step();

        // 300 illegal opcodes: counter saturates at 255
        in_valid = 1'b1; opcode = 7'h7F; rd = 5'd4;
        for (int i = 1; i <= 300; i++) begin
            #1 chk("il_flag", illegal, 1);
            step();
            chk("il_cnt", illegal_cnt, (i > 255) ? 255 : i);
            chk("il_ex_zero", {ex_valid, ex_branch, ex_jump, ex_alusrc, ex_memread,
                               ex_aluop, ex_rd}, 0);
            if (i > 3) chk("il_down_zero", {mem_valid, wb_valid}, 0);
        end
        reset = 1'b1;
        step();
        chk("il_reset_cnt", illegal_cnt, 0);
        chk("il_reset_valids", {ex_valid, mem_valid, wb_valid}, 0);
        reset = 1'b0;
        step();
        chk("il_cnt_restart", illegal_cnt, 1);
        in_valid = 1'b0;
        #1 chk("il_flag_invalid", illegal, 0);
        step();

        chk("queue_drained", wb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter REG_W, default 5: register-index width of rs1/rs2/rd and all stage rd outputs.
REQ-002 Parameter ALUOP_W, default 2: ALUOp width; codes are zero-extended to ALUOP_W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  IF/ID holds a valid instruction.
REQ-006 opcode  in  7  instruction[6:0] from IF/ID.
REQ-007 rs1, rs2, rd  in  REG_W each  source and destination indices from IF/ID.
REQ-008 stall_in  in  1  external freeze (memory wait); hold all stage registers.
REQ-009 flush  in  1  taken branch/jump; squash the instruction currently in ID.
REQ-010 id_stall  out  1  hold PC and IF/ID this cycle.
REQ-011 ex_valid, ex_branch, ex_jump, ex_alusrc, ex_memread  out  1 each; ex_aluop  out  ALUOP_W; ex_rd  out  REG_W: ID/EX register.
REQ-012 mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each; mem_rd  out  REG_W: EX/MEM register.
REQ-013 wb_valid, wb_regwrite, wb_memtoreg  out  1 each; wb_rd  out  REG_W: MEM/WB register.
REQ-014 illegal  out  1  combinational: in_valid with undecodable opcode.
REQ-015 illegal_cnt  out  8  saturating count of illegal instructions accepted into EX.

Function
REQ-016 Decode table (Branch,Jump,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp): 0110011 R 0,0,0,0,0,0,1,10; 0000011 load 0,0,1,1,0,1,1,00; 0010011 I-ALU 0,0,0,0,0,1,1,11; 0100011 store 0,0,0,0,1,1,0,00; 1100011 branch 1,0,0,0,0,0,0,01; 1100111 jalr and 1101111 jal 0,1,0,1,0,1,1,00.
REQ-017 Unlisted opcode: illegal=1 (when in_valid), all controls 0, no X on any output ever.
REQ-018 Bubble = valid 0 with every control bit 0 and rd 0.
REQ-019 Normal advance (stall_in=0, id_stall=0, flush=0): ID/EX <= decode with ex_valid=in_valid&~illegal; EX/MEM <= ID/EX; MEM/WB <= EX/MEM; latency ID to WB = 3 cycles.
REQ-020 Control bits not needed downstream are dropped per stage; memwrite/memtoreg/regwrite carried from ID/EX internal bits.
REQ-021 Any stage with valid=0 presents all controls 0 (a store/regwrite can never fire from a bubble).
REQ-022 flush=1 with stall_in=0: ID/EX <= bubble, EX/MEM and MEM/WB advance; id_stall forced 0.
REQ-023 stall_in=1: all three stage registers and illegal_cnt hold; id_stall=1; flush ignored (upstream holds flush until stall_in=0).
REQ-024 Load-use hazard (see REQ-030): ID/EX <= bubble, EX/MEM and MEM/WB advance, id_stall=1 for exactly one cycle per hazard.
REQ-025 id_stall = stall_in | (hazard & ~flush).
REQ-026 illegal_cnt increments when an illegal instruction would enter ID/EX under normal advance; saturates at 255, never wraps.
REQ-027 rd of instructions with RegWrite=0 stored as 0.

Reset
REQ-028 reset=1 on a clock edge: all stage registers become bubbles, illegal_cnt=0; reset overrides stall_in and flush.
REQ-029 First cycle after reset deassertion: all valid outputs 0, id_stall=stall_in.

Configuration
REQ-030 Macro PIPE_CTRL_HAZARD_DETECT_EN defined: hazard = in_valid & ~illegal & ex_valid & ex_memread & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)); uses_rs1 for all decoded opcodes except jal; uses_rs2 for R, store, branch.
REQ-031 Macro undefined: hazard constant 0; id_stall = stall_in; no comparators synthesised; all else identical.

Verification
REQ-032 Reset, then opcode 0110011, rd=5, in_valid=1 -> ex_valid=1, ex_aluop=10 next cycle; wb_valid=1, wb_regwrite=1, wb_rd=5 after 3 cycles.
REQ-033 Load rd=3 then R with rs2=3 (HAZARD_DETECT_EN) -> id_stall=1 one cycle, bubble at EX, R enters EX next cycle; without macro id_stall stays 0.
REQ-034 Load rd=0 then R rs1=0 -> id_stall=0.
REQ-035 flush=1 with store in ID -> ex_valid=0, mem_memwrite never 1 for that store; stall_in=1 with flush=1 -> all stages hold, id_stall=1.
REQ-036 300 consecutive opcode 1111111 -> illegal=1 each cycle, all outputs 0, illegal_cnt stops at 255; reset mid-stream -> illegal_cnt=0 and all valids 0 next cycle.
